// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: op and FSM encodings,
// default datapath width and small op-decoding helpers.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef logic [1:0] op_t;

  localparam op_t OP_MULTU = 2'b00;
  localparam op_t OP_MULT  = 2'b01;
  localparam op_t OP_DIVU  = 2'b10;
  localparam op_t OP_DIV   = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // Bit 1 selects divide, bit 0 selects the signed variant.
  function automatic logic op_is_div(input op_t op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_t op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Core-side bundle for the multiply/divide unit: launch request, MTHI/MTLO writes
// and the HI/LO/status read-back.
interface muldiv_sequencer_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
);
  logic             start;
  op_t              op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: right-shifting shift-add for multiply, restoring
// shift-subtract on {remainder, quotient} for divide. Purely combinational.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH-1:0]   div_diff;
  logic               div_fits;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    // The trial remainder is strictly below 2*divisor, so a WIDTH-bit
    // difference is exact whenever the subtraction is kept.
    div_trial = acc[2*WIDTH-1:WIDTH-1];
    div_fits  = (div_trial >= {1'b0, operand});
    div_diff  = div_trial[WIDTH-1:0] - operand;
    if (div_fits) begin
      div_next = {div_diff, acc[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {acc[2*WIDTH-2:0], 1'b0};
    end

    acc_next = is_div ? div_next : mul_next;
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO: magnitudes are iterated for WIDTH
// cycles, then signs are fixed up and HI/LO written in a single FIX cycle.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input logic              clk,
  input logic              rst_n,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]         state_reg;
  logic [CW-1:0]      count_reg;
  op_t                op_reg;
  logic               sign_a_reg;
  logic               sign_b_reg;
  logic [WIDTH-1:0]   a_raw_reg;
  logic [WIDTH-1:0]   b_abs_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               done_reg;
  logic               dbz_reg;

  logic               sign_a_next;
  logic               sign_b_next;
  logic [WIDTH-1:0]   a_abs_next;
  logic [WIDTH-1:0]   b_abs_next;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic               div_zero;
  logic [WIDTH-1:0]   hi_next;
  logic [WIDTH-1:0]   lo_next;

  always_comb begin
    sign_a_next = op_is_signed(bus.op) & bus.src_a[WIDTH-1];
    sign_b_next = op_is_signed(bus.op) & bus.src_b[WIDTH-1];
    a_abs_next  = sign_a_next ? -bus.src_a : bus.src_a;
    b_abs_next  = sign_b_next ? -bus.src_b : bus.src_b;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (op_is_div(op_reg)),
    .acc      (acc_reg),
    .operand  (b_abs_reg),
    .acc_next (acc_next)
  );

  // Sign correction of the unsigned magnitude result. MIN / -1 needs no special
  // case: the magnitude quotient is MIN and negating it wraps back to MIN.
  always_comb begin
    quo      = acc_reg[WIDTH-1:0];
    rem      = acc_reg[2*WIDTH-1:WIDTH];
    div_zero = (b_abs_reg == '0);
    prod_fix = (op_reg == OP_MULT && (sign_a_reg ^ sign_b_reg)) ? -acc_reg : acc_reg;
    hi_next  = prod_fix[2*WIDTH-1:WIDTH];
    lo_next  = prod_fix[WIDTH-1:0];
    if (op_is_div(op_reg)) begin
      if (div_zero) begin
        hi_next = a_raw_reg;
        lo_next = '1;
      end else begin
        lo_next = (op_is_signed(op_reg) && (sign_a_reg ^ sign_b_reg)) ? -quo : quo;
        hi_next = (op_is_signed(op_reg) && sign_a_reg) ? -rem : rem;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      op_reg     <= OP_MULTU;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      a_raw_reg  <= '0;
      b_abs_reg  <= '0;
      acc_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
      dbz_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            state_reg  <= ST_RUN;
            count_reg  <= CW'(WIDTH - 1);
            op_reg     <= bus.op;
            sign_a_reg <= sign_a_next;
            sign_b_reg <= sign_b_next;
            a_raw_reg  <= bus.src_a;
            b_abs_reg  <= b_abs_next;
            acc_reg    <= {{WIDTH{1'b0}}, a_abs_next};
            dbz_reg    <= 1'b0;
          end else begin
            if (bus.hi_we) hi_reg <= bus.wdata;
            if (bus.lo_we) lo_reg <= bus.wdata;
          end
        end
        ST_RUN: begin
          acc_reg   <= acc_next;
          count_reg <= count_reg - 1'b1;
          if (count_reg == '0) state_reg <= ST_FIX;
        end
        ST_FIX: begin
          hi_reg    <= hi_next;
          lo_reg    <= lo_next;
          done_reg  <= 1'b1;
          dbz_reg   <= op_is_div(op_reg) & div_zero;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy        = (state_reg != ST_IDLE);
  assign bus.done        = done_reg;
  assign bus.div_by_zero = dbz_reg;
  assign bus.hi          = hi_reg;
  assign bus.lo          = lo_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases followed by
// random operations compared against an arithmetic reference model.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Reference: plain machine arithmetic on full-width integers.
  function automatic res_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    logic [63:0] up;
    longint sp;
    int sa, sb;
    r = '0;
    case (o)
      2'b00: begin
        up = 64'(a) * 64'(b);
        r.hi = up[63:32]; r.lo = up[31:0];
      end
      2'b01: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        up = 64'(sp);
        r.hi = up[63:32]; r.lo = up[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          r.dbz = 1'b1; r.hi = a; r.lo = 32'hFFFF_FFFF;
        end else if (o == 2'b10) begin
          r.hi = a % b; r.lo = a / b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r.hi = 32'd0; r.lo = 32'h8000_0000;
        end else begin
          sa = $signed(a); sb = $signed(b);
          r.hi = 32'(sa % sb); r.lo = 32'(sa / sb);
        end
      end
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
    tick();
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    // Operands must have been captured at the start edge.
    bus.src_a = $urandom; bus.src_b = $urandom;
  endtask

  // Waits for done after issue(); returns cycles from the start edge (-1 on timeout).
  task automatic wait_done(input logic [31:0] old_hi, input logic [31:0] old_lo,
                           output int cyc, output int busy_cnt, output logic held);
    cyc = -1; busy_cnt = 0; held = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.hi !== old_hi || bus.lo !== old_lo) held = 1'b0;
      tick();
      if (bus.done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic run_and_check(input string tag, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input res_t e);
    int cyc, busy_cnt;
    logic held;
    logic [31:0] old_hi, old_lo;
    old_hi = bus.hi; old_lo = bus.lo;
    issue(o, a, b);
    check({tag, ".busy_at_start"}, bus.busy, 1);
    check({tag, ".dbz_cleared"}, bus.div_by_zero, 0);
    wait_done(old_hi, old_lo, cyc, busy_cnt, held);
    $display("op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h dbz=%0d cycles=%0d",
             o, a, b, bus.hi, bus.lo, bus.div_by_zero, cyc);
    check({tag, ".latency"}, cyc, W + 1);
    check({tag, ".busy_cycles"}, busy_cnt, W + 1);
    check({tag, ".hilo_held"}, held, 1);
    check({tag, ".hi"}, bus.hi, e.hi);
    check({tag, ".lo"}, bus.lo, e.lo);
    check({tag, ".dbz"}, bus.div_by_zero, e.dbz);
    check({tag, ".busy_after"}, bus.busy, 0);
    tick();
    check({tag, ".done_pulse"}, bus.done, 0);
  endtask

  initial begin
    int cyc, busy_cnt;
    logic held;
    logic [1:0] o;
    logic [31:0] a, b;
    int sel;
    res_t e;

    bus.start = 1'b0; bus.op = OP_MULTU; bus.src_a = '0; bus.src_b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset.busy", bus.busy, 0);
    check("reset.done", bus.done, 0);
    check("reset.dbz", bus.div_by_zero, 0);
    check("reset.hi", bus.hi, 0);
    check("reset.lo", bus.lo, 0);
    rst_n = 1'b1;
    tick();

    run_and_check("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  '{dbz: 1'b0, hi: 32'hFFFF_FFFE, lo: 32'h0000_0001});
    run_and_check("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7,
                  '{dbz: 1'b0, hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB});
    run_and_check("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2,
                  '{dbz: 1'b0, hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD});
    run_and_check("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                  '{dbz: 1'b0, hi: 32'h0, lo: 32'h8000_0000});
    run_and_check("divu_zero", OP_DIVU, 32'd5, 32'd0,
                  '{dbz: 1'b1, hi: 32'd5, lo: 32'hFFFF_FFFF});
    tick();
    check("divu_zero.dbz_sticky", bus.div_by_zero, 1);
    run_and_check("div_zero_neg", OP_DIV, 32'hFFFF_FFF0, 32'd0,
                  '{dbz: 1'b1, hi: 32'hFFFF_FFF0, lo: 32'hFFFF_FFFF});

    // Start and MTHI/MTLO in the same IDLE cycle: start wins.
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    run_and_check("start_vs_mt", OP_MULTU, 32'd2, 32'd5,
                  '{dbz: 1'b0, hi: 32'd0, lo: 32'd10});

    // Mid-run start and MTHI are ignored.
    issue(OP_MULTU, 32'd3, 32'd4);
    repeat (4) tick();
    bus.start = 1'b1; bus.op = OP_DIVU; bus.src_a = 32'd100; bus.src_b = 32'd7;
    bus.hi_we = 1'b1; bus.wdata = 32'hAA;
    tick();
    bus.start = 1'b0; bus.hi_we = 1'b0;
    wait_done(32'd0, 32'd10, cyc, busy_cnt, held);
    $display("midrun: hi=0x%08h lo=0x%08h cycles_after_inject=%0d", bus.hi, bus.lo, cyc);
    check("midrun.latency", cyc, W + 1 - 5);
    check("midrun.hilo_held", held, 1);
    check("midrun.hi", bus.hi, 32'd0);
    check("midrun.lo", bus.lo, 32'd12);
    tick();
    check("midrun.no_restart", bus.busy, 0);

    // MTLO then MTHI+MTLO in IDLE.
    bus.lo_we = 1'b1; bus.wdata = 32'h55;
    tick();
    bus.lo_we = 1'b0;
    $display("mtlo: hi=0x%08h lo=0x%08h done=%0d", bus.hi, bus.lo, bus.done);
    check("mtlo.lo", bus.lo, 32'h55);
    check("mtlo.hi", bus.hi, 32'd0);
    check("mtlo.done", bus.done, 0);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h1234_5678;
    tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    $display("mthi+mtlo: hi=0x%08h lo=0x%08h done=%0d", bus.hi, bus.lo, bus.done);
    check("mtboth.hi", bus.hi, 32'h1234_5678);
    check("mtboth.lo", bus.lo, 32'h1234_5678);
    check("mtboth.done", bus.done, 0);

    // Asynchronous reset in the middle of a DIV.
    issue(OP_DIV, 32'hFFFF_0000, 32'd3);
    repeat (9) tick();
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: busy=%0d done=%0d hi=0x%08h lo=0x%08h", bus.busy, bus.done, bus.hi, bus.lo);
    check("arst.busy", bus.busy, 0);
    check("arst.done", bus.done, 0);
    check("arst.hi", bus.hi, 0);
    check("arst.lo", bus.lo, 0);
    check("arst.dbz", bus.div_by_zero, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_and_check("post_reset", OP_MULTU, 32'd2, 32'd3,
                  '{dbz: 1'b0, hi: 32'd0, lo: 32'd6});

    // Random operations against the reference model.
    for (int n = 0; n < 24; n++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
        default: b = $urandom;
      endcase
      if (sel == 1 && o[1] == 1'b0) o = OP_DIV;
      e = model(o, a, b);
      run_and_check($sformatf("rand%0d", n), o, a, b, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit with HI/LO registers for the MIPS core. It executes MULT, MULTU, DIV and DIVU in WIDTH+1 cycles, one radix-2 step per cycle.
- It sits beside the ALU in the execute path and owns the HI/LO state. The core stalls on busy before reading HI/LO or issuing another start.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be ≥ 4 and even.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch operation; sampled only in IDLE
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- src_a  in  WIDTH  multiplicand / dividend
- src_b  in  WIDTH  multiplier / divisor
- hi_we  in  1  MTHI write
- lo_we  in  1  MTLO write
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse when HI/LO are updated by an op
- div_by_zero  out  1  last division had divisor 0 (sticky until next start)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; internal accumulators and counter cleared. Assertion mid-operation aborts the op; no partial result reaches hi/lo.
- States:
  - IDLE -> RUN on start. At that edge: latch op; latch |src_a| and |src_b| (absolute values only for signed ops); record sign_a and sign_b; count=WIDTH-1; clear div_by_zero.
  - RUN: one iteration per cycle.
    - Multiply: shift-add on a 2*WIDTH accumulator.
    - Divide: restoring shift-subtract on a {remainder, quotient} pair.
    - Decrement count; at count==0 go to FIX. RUN lasts exactly WIDTH cycles.
  - FIX -> IDLE. Apply sign correction, write hi/lo, assert done for the following cycle. div_by_zero is set here when the divisor was 0.
- busy = (state != IDLE): high for WIDTH+1 cycles. For start sampled at edge E0, hi/lo/done update at edge E0+WIDTH+1.
- done is registered; high exactly one cycle; never asserted for MTHI/MTLO.
- Multiply result: 2*WIDTH product; hi = upper half, lo = lower half.
  - MULT: product negated when sign_a ^ sign_b.
  - Two's-complement wrap throughout.
- Divide result: lo = quotient, hi = remainder.
  - DIV: quotient negated when sign_a ^ sign_b; remainder takes sign_a (truncating division).
  - DIV overflow, most-negative / -1: lo = most-negative, hi = 0. No flag.
- Divisor 0, DIV or DIVU: lo = all ones, hi = src_a unmodified (original signed value, no sign fix); div_by_zero=1.
- MTHI/MTLO: in IDLE, a write takes effect at the next edge. Writes while busy are ignored (core contract: stall).
- Simultaneous events:
  - start with hi_we/lo_we in IDLE: start wins, writes discarded.
  - start while busy: ignored.
  - hi_we and lo_we together: both written with wdata.
- Operands are consumed only at the start edge; src_a/src_b changes during RUN have no effect.
- hi/lo hold their value throughout RUN and FIX, so old results stay readable until done.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV)
  - state encoding (IDLE, RUN, FIX)
  - WIDTH default constant
- One natural combinational sub-module, muldiv_step: given op class, accumulator and operand, returns the next accumulator for one multiply or divide iteration. The top holds the FSM, counter, sign logic and HI/LO registers.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy high 33 cycles; done one cycle at start+33; hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD(-3)*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV:
  - 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1; next start clears div_by_zero.
- Start MULTU 3*4, then pulse start (op DIVU) and hi_we (wdata=0xAA) mid-run -> both ignored; result hi=0, lo=12. Then in IDLE, mtlo 0x55 -> lo=0x55 next cycle, done stays 0.
- rst_n low at cycle 10 of a DIV -> busy, done, hi, lo immediately 0. After release, MULTU 2*3 completes normally: lo=6, hi=0.
